// File: rtl/nth_root_fx.sv
// Fixed-point k-th root: floor(x^(1/k) * 2^FRAC_W) by bit-by-bit trial with one multiply per cycle.
// Define ROOT_ROUND_EN to search one guard bit deeper and return a round-half-up result.
module nth_root_fx #(
  parameter int DIN_W  = 10,
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 10,
  parameter int RES_W  = DIN_W + FRAC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIN_W-1:0]   in_data,
  input  logic [EXP_W-1:0]   in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_data,
  output logic               out_err
);

`ifdef ROOT_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif
  localparam int SW   = RES_W + GUARD;          // search width
  localparam int FS   = FRAC_W + GUARD;         // target shift per unit of k
  localparam int KMAX = (1 << EXP_W) - 1;
  localparam int XW   = DIN_W + FS * KMAX;      // widest target X
  localparam int PW   = XW + SW;                // full product width

  typedef enum logic [1:0] {IDLE, MUL, DECIDE, DONE} state_e;

  state_e             state_q, state_d;
  logic [DIN_W-1:0]   x_q, x_d;
  logic [EXP_W-1:0]   k_q, k_d;
  logic [EXP_W-1:0]   j_q, j_d;
  logic [SW-1:0]      res_q, res_d;
  logic [SW-1:0]      mask_q, mask_d;
  logic [XW-1:0]      acc_q, acc_d;
  logic               over_q, over_d;
  logic [RES_W-1:0]   data_q, data_d;
  logic               err_q, err_d;

  logic [XW-1:0]      target;
  logic [SW-1:0]      cand;
  logic [PW-1:0]      prod;
  logic               prod_over;
  logic               keep_bit;
  logic               exact;
  logic [SW-1:0]      res_set;
  logic [SW-1:0]      mask_next;
  logic [RES_W-1:0]   res_final;

  assign target    = XW'(x_q) << (FS * int'(k_q));
  assign cand      = res_q | mask_q;
  assign prod      = PW'(acc_q) * PW'(cand);
  assign prod_over = prod > PW'(target);
  // acc only ever holds c^k when no overflow occurred, so it is compared exactly here
  assign keep_bit  = !over_q && (acc_q <= target);
  assign exact     = keep_bit && (acc_q == target);
  assign res_set   = keep_bit ? (res_q | mask_q) : res_q;
  assign mask_next = mask_q >> 1;

`ifdef ROOT_ROUND_EN
  logic [SW:0] rnd;
  assign rnd       = ({1'b0, res_set} + (SW+1)'(1)) >> 1;
  assign res_final = (rnd > (SW+1)'({RES_W{1'b1}})) ? {RES_W{1'b1}} : rnd[RES_W-1:0];
`else
  assign res_final = res_set;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    k_d     = k_q;
    j_d     = j_q;
    res_d   = res_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    over_d  = over_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d    = in_data;
          k_d    = in_exp;
          data_d = '0;
          err_d  = 1'b0;
          if (in_exp == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (in_exp == EXP_W'(1)) begin
            data_d  = RES_W'(in_data) << FRAC_W;
            state_d = DONE;
          end else if (in_data == '0) begin
            state_d = DONE;
          end else begin
            res_d   = '0;
            mask_d  = {1'b1, {(SW-1){1'b0}}};
            acc_d   = XW'({1'b1, {(SW-1){1'b0}}});
            j_d     = EXP_W'(1);
            over_d  = 1'b0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (prod_over) over_d = 1'b1;
        else           acc_d  = prod[XW-1:0];
        j_d = j_q + EXP_W'(1);
        if (prod_over || ((j_q + EXP_W'(1)) == k_q)) state_d = DECIDE;
      end
      DECIDE: begin
        res_d = res_set;
        if (exact || mask_q[0]) begin
          data_d  = res_final;
          state_d = DONE;
        end else begin
          mask_d  = mask_next;
          acc_d   = XW'(res_set | mask_next);
          j_d     = EXP_W'(1);
          over_d  = 1'b0;
          state_d = MUL;
        end
      end
      DONE: begin
        if (out_ready) begin
          data_d  = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      k_q     <= '0;
      j_q     <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      over_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      j_q     <= j_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      over_q  <= over_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
